// File: rtl/ktane_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ktane_bus_pkg
// Description : Shared types and constants for the ktane_mem bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ktane_bus_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } bus_state_e;

    // Requester port indices
    localparam int PORT_CPU = 0;
    localparam int PORT_AUX = 1;

    // Legal memory read latency range (cycles from issue to valid mem_q)
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    // Width of the read latency down-counter
    localparam int CNT_W = 2;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational 2-way round-robin winner selection. On a tie
//               the port that was not granted most recently wins.
// Revision    : 1.0 - initial release
// ============================================================================
import ktane_bus_pkg::*;

module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);

    // Lone requester wins outright; a tie goes to the port opposite 'last'
    always_comb begin
        any    = |req;
        winner = (req == 2'b11) ? ~last : req[PORT_AUX];
    end

endmodule
`default_nettype wire

// File: rtl/ktane_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ktane_bus_arbiter
// Description : Round-robin arbiter sharing the single ktane_mem load/store
//               port between the CPU datapath and an auxiliary master. One
//               transaction in flight at a time; read data returned after a
//               fixed memory latency. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
import ktane_bus_pkg::*;

module ktane_bus_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    // Counter preload; out-of-range latencies are clamped to the legal range
    localparam logic [CNT_W-1:0] c_CNT_LOAD =
        (RD_LAT < RD_LAT_MIN) ? CNT_W'(RD_LAT_MIN - 1) :
        (RD_LAT > RD_LAT_MAX) ? CNT_W'(RD_LAT_MAX - 1) :
                                CNT_W'(RD_LAT - 1);

    bus_state_e        r_state, w_state_nxt;
    logic              r_owner, w_owner_nxt;
    logic              r_last,  w_last_nxt;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic              w_we_nxt;
    logic [1:0]        w_gnt_nxt;
    logic [1:0]        w_rvalid_nxt;
    logic [DATA_W-1:0] w_rdata_nxt;
    logic              w_winner;
    logic              w_any;

    rr_pick2 u_pick (
        .req    (req),
        .last   (r_last),
        .winner (w_winner),
        .any    (w_any)
    );

    // State and registered-output update; reset abandons any transaction
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_owner  <= 1'(PORT_CPU);
            r_last   <= 1'b1;
            r_cnt    <= '0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
            gnt      <= 2'b00;
            rvalid   <= 2'b00;
            rdata    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_last   <= w_last_nxt;
            r_cnt    <= w_cnt_nxt;
            mem_addr <= w_addr_nxt;
            mem_data <= w_data_nxt;
            mem_we   <= w_we_nxt;
            gnt      <= w_gnt_nxt;
            rvalid   <= w_rvalid_nxt;
            rdata    <= w_rdata_nxt;
        end
    end

    // Next-state and next-output logic; pulses default low, data holds
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_last_nxt   = r_last;
        w_cnt_nxt    = r_cnt;
        w_addr_nxt   = mem_addr;
        w_data_nxt   = mem_data;
        w_we_nxt     = 1'b0;
        w_gnt_nxt    = 2'b00;
        w_rvalid_nxt = 2'b00;
        w_rdata_nxt  = rdata;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_owner_nxt          = w_winner;
                    w_gnt_nxt[w_winner]  = 1'b1;
                    w_we_nxt             = we[w_winner];
                    if (w_winner == 1'(PORT_AUX)) begin
                        w_addr_nxt = addr1;
                        w_data_nxt = wdata1;
                    end else begin
                        w_addr_nxt = addr0;
                        w_data_nxt = wdata0;
                    end
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // mem_we mirrors the owner's write flag during the issue cycle
                w_last_nxt = r_owner;
                if (mem_we) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt   = c_CNT_LOAD;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_rdata_nxt           = mem_q;
                    w_rvalid_nxt[r_owner] = 1'b1;
                    w_state_nxt           = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ktane_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ktane_bus_arbiter
// Description : Directed self-checking bench for ktane_bus_arbiter. Two
//               instances share stimulus: dut1 with RD_LAT=1, dut3 with
//               RD_LAT=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ktane_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req   = 2'b00;
    logic [1:0]  we    = 2'b00;
    logic [15:0] addr0 = '0;
    logic [15:0] addr1 = '0;
    logic [15:0] wdata0 = '0;
    logic [15:0] wdata1 = '0;
    logic [15:0] mem_q = 16'hDEAD;

    logic [1:0]  gnt1, rvalid1, gnt3, rvalid3;
    logic [15:0] rdata1, mem_addr1, mem_data1;
    logic [15:0] rdata3, mem_addr3, mem_data3;
    logic        mem_we1, mem_we3;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ktane_bus_arbiter #(.DATA_W(16), .ADDR_W(16), .RD_LAT(1)) dut1 (
        .clock(clock), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1),
        .mem_addr(mem_addr1), .mem_data(mem_data1), .mem_we(mem_we1),
        .mem_q(mem_q)
    );

    ktane_bus_arbiter #(.DATA_W(16), .ADDR_W(16), .RD_LAT(3)) dut3 (
        .clock(clock), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3),
        .mem_addr(mem_addr3), .mem_data(mem_data3), .mem_we(mem_we3),
        .mem_q(mem_q)
    );

    // Advance one clock and settle just past the rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        req   = 2'b00;
        we    = 2'b00;
        mem_q = 16'hDEAD;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (gnt1 !== 2'b00) begin failures++; $display("FAIL reset_gnt: got %b want 00", gnt1); end
        checks++; if (rvalid1 !== 2'b00) begin failures++; $display("FAIL reset_rvalid: got %b want 00", rvalid1); end
        checks++; if (mem_we1 !== 1'b0) begin failures++; $display("FAIL reset_mem_we: got %b want 0", mem_we1); end
        checks++; if (mem_addr1 !== 16'h0000) begin failures++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr1); end
        checks++; if (mem_data1 !== 16'h0000) begin failures++; $display("FAIL reset_mem_data: got %h want 0000", mem_data1); end
        checks++; if (rdata1 !== 16'h0000) begin failures++; $display("FAIL reset_rdata: got %h want 0000", rdata1); end
    endtask

    task automatic test_write_port0();
        do_reset();
        req = 2'b01; we = 2'b01; addr0 = 16'h0040; wdata0 = 16'h1234;
        tick(); // t+1
        req = 2'b00;
        checks++; if (gnt1 !== 2'b01) begin failures++; $display("FAIL wr_gnt: got %b want 01", gnt1); end
        checks++; if (mem_we1 !== 1'b1) begin failures++; $display("FAIL wr_mem_we: got %b want 1", mem_we1); end
        checks++; if (mem_addr1 !== 16'h0040) begin failures++; $display("FAIL wr_mem_addr: got %h want 0040", mem_addr1); end
        checks++; if (mem_data1 !== 16'h1234) begin failures++; $display("FAIL wr_mem_data: got %h want 1234", mem_data1); end
        tick(); // t+2
        checks++; if (mem_we1 !== 1'b0) begin failures++; $display("FAIL wr_mem_we_drop: got %b want 0", mem_we1); end
        checks++; if (gnt1 !== 2'b00) begin failures++; $display("FAIL wr_gnt_drop: got %b want 00", gnt1); end
        checks++; if (mem_addr1 !== 16'h0040) begin failures++; $display("FAIL wr_addr_hold: got %h want 0040", mem_addr1); end
    endtask

    task automatic test_read_port1();
        do_reset();
        req = 2'b10; we = 2'b00; addr1 = 16'h0010;
        tick(); // t+1
        req = 2'b00;
        checks++; if (gnt1 !== 2'b10) begin failures++; $display("FAIL rd_gnt: got %b want 10", gnt1); end
        checks++; if (mem_we1 !== 1'b0) begin failures++; $display("FAIL rd_mem_we: got %b want 0", mem_we1); end
        checks++; if (mem_addr1 !== 16'h0010) begin failures++; $display("FAIL rd_mem_addr: got %h want 0010", mem_addr1); end
        tick(); // t+2: memory data valid this cycle
        mem_q = 16'hBEEF;
        checks++; if (rvalid1 !== 2'b00) begin failures++; $display("FAIL rd_rvalid_early: got %b want 00", rvalid1); end
        tick(); // t+3
        mem_q = 16'hDEAD;
        checks++; if (rvalid1 !== 2'b10) begin failures++; $display("FAIL rd_rvalid: got %b want 10", rvalid1); end
        checks++; if (rdata1 !== 16'hBEEF) begin failures++; $display("FAIL rd_rdata: got %h want BEEF", rdata1); end
        tick(); // t+4
        checks++; if (rvalid1 !== 2'b00) begin failures++; $display("FAIL rd_rvalid_drop: got %b want 00", rvalid1); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_gnt  [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        logic [15:0] exp_addr [8] = '{16'h0100, 16'h0100, 16'h0200, 16'h0200, 16'h0100, 16'h0100, 16'h0200, 16'h0200};
        logic [15:0] exp_data [8] = '{16'hAAAA, 16'hAAAA, 16'h5555, 16'h5555, 16'hAAAA, 16'hAAAA, 16'h5555, 16'h5555};
        do_reset();
        req = 2'b11; we = 2'b11;
        addr0 = 16'h0100; wdata0 = 16'hAAAA;
        addr1 = 16'h0200; wdata1 = 16'h5555;
        for (int i = 0; i < 8; i++) begin
            tick(); // t+1+i
            checks++; if (gnt1 !== exp_gnt[i]) begin failures++; $display("FAIL b2b_gnt[%0d]: got %b want %b", i, gnt1, exp_gnt[i]); end
            checks++; if (mem_we1 !== (exp_gnt[i] != 2'b00)) begin failures++; $display("FAIL b2b_mem_we[%0d]: got %b want %b", i, mem_we1, (exp_gnt[i] != 2'b00)); end
            checks++; if (mem_addr1 !== exp_addr[i]) begin failures++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, mem_addr1, exp_addr[i]); end
            checks++; if (mem_data1 !== exp_data[i]) begin failures++; $display("FAIL b2b_data[%0d]: got %h want %h", i, mem_data1, exp_data[i]); end
        end
        req = 2'b00;
    endtask

    task automatic test_read_lat3();
        do_reset();
        req = 2'b01; we = 2'b00; addr0 = 16'h0077;
        tick(); // t+1
        req = 2'b00;
        checks++; if (gnt3 !== 2'b01) begin failures++; $display("FAIL lat3_gnt: got %b want 01", gnt3); end
        tick(); // t+2: port 1 raises a write request
        req = 2'b10; we = 2'b10; addr1 = 16'h0099; wdata1 = 16'h4321;
        checks++; if (rvalid3 !== 2'b00) begin failures++; $display("FAIL lat3_rvalid_t2: got %b want 00", rvalid3); end
        tick(); // t+3
        checks++; if (gnt3 !== 2'b00) begin failures++; $display("FAIL lat3_gnt_t3: got %b want 00", gnt3); end
        tick(); // t+4: memory data valid this cycle
        mem_q = 16'hCAFE;
        checks++; if (gnt3 !== 2'b00 || rvalid3 !== 2'b00) begin failures++; $display("FAIL lat3_t4: got gnt %b rvalid %b want 00 00", gnt3, rvalid3); end
        tick(); // t+5
        mem_q = 16'hDEAD;
        checks++; if (rvalid3 !== 2'b01) begin failures++; $display("FAIL lat3_rvalid: got %b want 01", rvalid3); end
        checks++; if (rdata3 !== 16'hCAFE) begin failures++; $display("FAIL lat3_rdata: got %h want CAFE", rdata3); end
        checks++; if (gnt3 !== 2'b00) begin failures++; $display("FAIL lat3_gnt_t5: got %b want 00", gnt3); end
        tick(); // t+6
        req = 2'b00;
        checks++; if (gnt3 !== 2'b10) begin failures++; $display("FAIL lat3_p1_gnt: got %b want 10", gnt3); end
        checks++; if (mem_addr3 !== 16'h0099 || mem_we3 !== 1'b1) begin failures++; $display("FAIL lat3_p1_mem: got addr %h we %b want 0099 1", mem_addr3, mem_we3); end
        tick();
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        req = 2'b01; we = 2'b00; addr0 = 16'h0055;
        tick(); // t+1 ISSUE
        req = 2'b00;
        tick(); // t+2 WAIT
        reset = 1'b1;
        mem_q = 16'hBEEF;
        tick();
        reset = 1'b0;
        checks++; if (gnt3 !== 2'b00 || rvalid3 !== 2'b00 || mem_we3 !== 1'b0) begin failures++; $display("FAIL rstw_ctrl: got gnt %b rvalid %b we %b want 00 00 0", gnt3, rvalid3, mem_we3); end
        checks++; if (mem_addr3 !== 16'h0000 || mem_data3 !== 16'h0000 || rdata3 !== 16'h0000) begin failures++; $display("FAIL rstw_data: got addr %h data %h rdata %h want 0000 0000 0000", mem_addr3, mem_data3, rdata3); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (rvalid3 !== 2'b00) begin failures++; $display("FAIL rstw_no_rvalid[%0d]: got %b want 00", i, rvalid3); end
        end
        mem_q = 16'hDEAD;
        req = 2'b11; we = 2'b11; wdata0 = 16'h0F0F; wdata1 = 16'hF0F0;
        tick();
        req = 2'b00;
        checks++; if (gnt3 !== 2'b01) begin failures++; $display("FAIL rstw_tie_gnt: got %b want 01", gnt3); end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_port0();
        test_read_port1();
        test_back_to_back();
        test_read_lat3();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
